// File: rtl/key_entry_collector.sv
// Collects debounced strobe presses into a KEY_WIDTH-bit code (MSB first) and
// presents the completed code on InputKey with ValidCmd held for HOLD_CYCLES.
module key_entry_collector #(
  parameter int unsigned KEY_WIDTH       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 5,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               KeyBit,
  input  logic                               StrobeBtn,
  input  logic                               ClearBtn,
  output logic [KEY_WIDTH-1:0]               InputKey,
  output logic                               ValidCmd,
  output logic [$clog2(KEY_WIDTH+1)-1:0]     BitCount,
  output logic                               Busy
);

  localparam int unsigned CNT_W  = $clog2(KEY_WIDTH + 1);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SR_W   = KEY_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Synchronizer chains; index 1 is the synchronized value.
  logic [1:0] key_s;
  logic [1:0] strobe_s;
  logic [1:0] clear_s;

  // Debounce state.
  logic [DB_W-1:0] db_cnt;
  logic            db_level;
  logic            db_level_q;
  logic            press;

  // FSM state and datapath registers.
  state_t            state, state_n;
  logic [SR_W-1:0]   shreg, shreg_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [KEY_WIDTH-1:0] key_n;
  logic              valid_n;
  logic [CNT_W-1:0]  count_n;

  // Partial bits with the current synchronized key bit appended.
  logic [KEY_WIDTH-1:0] shifted_c;
  assign shifted_c = {shreg, key_s[1]};

  // Two-flop synchronizers for all asynchronous button/switch inputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_s    <= '0;
      strobe_s <= '0;
      clear_s  <= '0;
    end else begin
      key_s    <= {key_s[0], KeyBit};
      strobe_s <= {strobe_s[0], StrobeBtn};
      clear_s  <= {clear_s[0], ClearBtn};
    end
  end

  // Debouncer: level follows the strobe after DEBOUNCE_CYCLES stable cycles;
  // press is a registered one-cycle pulse on the debounced rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      db_cnt     <= '0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      press      <= 1'b0;
    end else begin
      db_level_q <= db_level;
      press      <= db_level & ~db_level_q;
      if (strobe_s[1] != db_level) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= strobe_s[1];
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Next-state and next-output logic for the entry FSM.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idle_n  = idle_cnt;
    hold_n  = hold_cnt;
    key_n   = InputKey;
    valid_n = ValidCmd;
    count_n = BitCount;

    if (clear_s[1]) begin
      state_n = IDLE;
      shreg_n = '0;
      idle_n  = '0;
      hold_n  = '0;
      key_n   = '0;
      valid_n = 1'b0;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state_n = COLLECT;
            shreg_n = SR_W'(key_s[1]);
            idle_n  = '0;
            count_n = CNT_W'(1);
          end
        end
        COLLECT: begin
          if (press) begin
            idle_n = '0;
            if (BitCount == CNT_W'(KEY_WIDTH - 1)) begin
              state_n = PRESENT;
              key_n   = shifted_c;
              valid_n = 1'b1;
              shreg_n = '0;
              hold_n  = '0;
              count_n = '0;
            end else begin
              shreg_n = shifted_c[SR_W-1:0];
              count_n = BitCount + CNT_W'(1);
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            state_n = IDLE;
            shreg_n = '0;
            idle_n  = '0;
            count_n = '0;
          end else begin
            idle_n = idle_cnt + IDLE_W'(1);
          end
        end
        PRESENT: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_n = IDLE;
            valid_n = 1'b0;
            hold_n  = '0;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      shreg    <= '0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      InputKey <= '0;
      ValidCmd <= 1'b0;
      BitCount <= '0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idle_cnt <= idle_n;
      hold_cnt <= hold_n;
      InputKey <= key_n;
      ValidCmd <= valid_n;
      BitCount <= count_n;
      Busy     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_key_entry_collector.sv
// Bench for key_entry_collector: scoreboard of expected codes checked on each
// ValidCmd rise; a second instance with a long hold window checks dropped presses.
module tb_key_entry_collector;

  localparam int unsigned KW     = 5;
  localparam int unsigned HOLD   = 5;
  localparam int unsigned HOLD_L = 16;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          KeyBit = 1'b0;
  logic          StrobeBtn = 1'b0;
  logic          ClearBtn = 1'b0;
  logic [KW-1:0] InputKey;
  logic          ValidCmd;
  logic [2:0]    BitCount;
  logic          Busy;
  logic [KW-1:0] input_key_l;
  logic          valid_l;
  logic [2:0]    bit_count_l;
  logic          busy_l;

  int vectors = 0;
  int miscompares = 0;
  logic [KW-1:0] exp_q[$];
  logic          skip_len = 1'b0;
  logic          prev_valid = 1'b0;
  int            run_len = 0;

  key_entry_collector #(.KEY_WIDTH(KW), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(HOLD),
                        .TIMEOUT_CYCLES(64)) dut (
    .Clk(Clk), .Reset(Reset), .KeyBit(KeyBit), .StrobeBtn(StrobeBtn),
    .ClearBtn(ClearBtn), .InputKey(InputKey), .ValidCmd(ValidCmd),
    .BitCount(BitCount), .Busy(Busy)
  );

  key_entry_collector #(.KEY_WIDTH(KW), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(HOLD_L),
                        .TIMEOUT_CYCLES(64)) dut_long (
    .Clk(Clk), .Reset(Reset), .KeyBit(KeyBit), .StrobeBtn(StrobeBtn),
    .ClearBtn(ClearBtn), .InputKey(input_key_l), .ValidCmd(valid_l),
    .BitCount(bit_count_l), .Busy(busy_l)
  );

  always #5 Clk = ~Clk;

  // Scoreboard monitor: code on every ValidCmd rise, pulse length on every fall.
  always @(negedge Clk) begin
    if (ValidCmd === 1'b1 && !prev_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got InputKey=%b with no code expected", InputKey);
      end else begin
        logic [KW-1:0] e;
        e = exp_q.pop_front();
        if (InputKey !== e) begin
          miscompares++;
          $display("FAIL code: got %b want %b", InputKey, e);
        end
      end
      run_len = 1;
    end else if (ValidCmd === 1'b1) begin
      run_len++;
    end else if (prev_valid && !skip_len) begin
      vectors++;
      if (run_len != HOLD) begin
        miscompares++;
        $display("FAIL hold_len: got %0d want %0d", run_len, HOLD);
      end
    end
    prev_valid = (ValidCmd === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic press(input logic b);
    KeyBit = b;
    StrobeBtn = 1'b1;
    tick(10);
    StrobeBtn = 1'b0;
    tick(10);
  endtask

  task automatic enter_code(input logic [KW-1:0] code);
    exp_q.push_back(code);
    for (int i = KW - 1; i >= 0; i--) press(code[i]);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      KeyBit = ~KeyBit; StrobeBtn = ~StrobeBtn; ClearBtn = ~ClearBtn;
      tick(1);
    end
    KeyBit = 1'b0; StrobeBtn = 1'b0; ClearBtn = 1'b0;
    tick(2);
    vectors++;
    if ({InputKey, ValidCmd, BitCount, Busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got key=%b v=%b cnt=%0d busy=%b want all 0",
               InputKey, ValidCmd, BitCount, Busy);
    end
    Reset = 1'b0;
    tick(3);
    vectors++;
    if (Busy !== 1'b0 || BitCount !== 3'd0) begin
      miscompares++;
      $display("FAIL after_reset_idle: got busy=%b cnt=%0d want 0 0", Busy, BitCount);
    end
  endtask

  task automatic test_entry;
    exp_q.push_back(5'b10101);
    press(1'b1); press(1'b0); press(1'b1); press(1'b0);
    vectors++;
    if (BitCount !== 3'd4 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_partial: got cnt=%0d busy=%b want 4 1", BitCount, Busy);
    end
    KeyBit = 1'b1;
    StrobeBtn = 1'b1;
    tick(7);
    vectors++;
    if (ValidCmd !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_early: got ValidCmd=%b want 0 at E0+6", ValidCmd);
    end
    tick(1);
    vectors++;
    if (ValidCmd !== 1'b1 || BitCount !== 3'd0 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL entry_latency: got v=%b cnt=%0d busy=%b want 1 0 1 at E0+7",
               ValidCmd, BitCount, Busy);
    end
    tick(2);
    StrobeBtn = 1'b0;
    tick(10);
    vectors++;
    if (InputKey !== 5'b10101 || ValidCmd !== 1'b0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_hold_key: got key=%b v=%b busy=%b want 10101 0 0",
               InputKey, ValidCmd, Busy);
    end
  endtask

  task automatic test_bounce;
    int lens[6] = '{1, 2, 3, 2, 3, 1};
    KeyBit = 1'b1;
    foreach (lens[i]) begin
      StrobeBtn = 1'b1; tick(lens[i]);
      StrobeBtn = 1'b0; tick(1);
    end
    tick(8);
    vectors++;
    if (BitCount !== 3'd0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_glitch: got cnt=%0d busy=%b want 0 0", BitCount, Busy);
    end
    press(1'b1);
    vectors++;
    if (BitCount !== 3'd1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bounce_one_bit: got cnt=%0d busy=%b want 1 1", BitCount, Busy);
    end
    tick(60);
    vectors++;
    if (Busy !== 1'b0 || BitCount !== 3'd0 || InputKey !== 5'b10101) begin
      miscompares++;
      $display("FAIL bounce_timeout: got busy=%b cnt=%0d key=%b want 0 0 10101",
               Busy, BitCount, InputKey);
    end
  endtask

  task automatic test_timeout;
    press(1'b1); press(1'b1); press(1'b0);
    tick(51);
    vectors++;
    if (BitCount !== 3'd3 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got cnt=%0d busy=%b want 3 1", BitCount, Busy);
    end
    tick(1);
    vectors++;
    if (BitCount !== 3'd0 || Busy !== 1'b0 || InputKey !== 5'b10101 || ValidCmd !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fire: got cnt=%0d busy=%b key=%b v=%b want 0 0 10101 0",
               BitCount, Busy, InputKey, ValidCmd);
    end
    enter_code(5'b00001);
    vectors++;
    if (InputKey !== 5'b00001) begin
      miscompares++;
      $display("FAIL timeout_next_code: got %b want 00001", InputKey);
    end
  endtask

  task automatic test_present_press;
    Reset = 1'b1; tick(2); Reset = 1'b0; tick(2);
    exp_q.push_back(5'b11001);
    press(1'b1); press(1'b1); press(1'b0); press(1'b0);
    KeyBit = 1'b1;
    StrobeBtn = 1'b1; tick(5);
    StrobeBtn = 1'b0; tick(6);
    StrobeBtn = 1'b1; tick(12);
    vectors++;
    if (valid_l !== 1'b1 || bit_count_l !== 3'd0 || busy_l !== 1'b1) begin
      miscompares++;
      $display("FAIL present_window: got v=%b cnt=%0d busy=%b want 1 0 1",
               valid_l, bit_count_l, busy_l);
    end
    vectors++;
    if (BitCount !== 3'd1 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL after_present_accept: got cnt=%0d busy=%b want 1 1", BitCount, Busy);
    end
    tick(1);
    vectors++;
    if (valid_l !== 1'b0 || bit_count_l !== 3'd0 || busy_l !== 1'b0 ||
        input_key_l !== 5'b11001) begin
      miscompares++;
      $display("FAIL present_dropped: got v=%b cnt=%0d busy=%b key=%b want 0 0 0 11001",
               valid_l, bit_count_l, busy_l, input_key_l);
    end
    StrobeBtn = 1'b0;
    tick(10);
  endtask

  task automatic test_clear;
    ClearBtn = 1'b1; tick(3);
    ClearBtn = 1'b0; tick(3);
    vectors++;
    if (InputKey !== 5'b00000 || BitCount !== 3'd0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_idle: got key=%b cnt=%0d busy=%b want 00000 0 0",
               InputKey, BitCount, Busy);
    end
    press(1'b1); press(1'b0); press(1'b1); press(1'b1);
    KeyBit = 1'b0;
    StrobeBtn = 1'b1; tick(5);
    ClearBtn = 1'b1; tick(1);
    ClearBtn = 1'b0; tick(1);
    vectors++;
    if (BitCount !== 3'd4 || Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_before: got cnt=%0d busy=%b want 4 1", BitCount, Busy);
    end
    tick(1);
    vectors++;
    if (ValidCmd !== 1'b0 || InputKey !== 5'b00000 || BitCount !== 3'd0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_wins: got v=%b key=%b cnt=%0d busy=%b want 0 00000 0 0",
               ValidCmd, InputKey, BitCount, Busy);
    end
    tick(2);
    StrobeBtn = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_present;
    skip_len = 1'b1;
    exp_q.push_back(5'b01110);
    press(1'b0); press(1'b1); press(1'b1); press(1'b1);
    KeyBit = 1'b0;
    StrobeBtn = 1'b1; tick(8);
    vectors++;
    if (ValidCmd !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_present_valid: got %b want 1", ValidCmd);
    end
    tick(1);
    Reset = 1'b1;
    StrobeBtn = 1'b0;
    tick(1);
    vectors++;
    if ({InputKey, ValidCmd, BitCount, Busy} !== '0) begin
      miscompares++;
      $display("FAIL rst_present: got key=%b v=%b cnt=%0d busy=%b want all 0",
               InputKey, ValidCmd, BitCount, Busy);
    end
    Reset = 1'b0;
    tick(10);
    skip_len = 1'b0;
    vectors++;
    if (BitCount !== 3'd0 || Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release_idle: got cnt=%0d busy=%b want 0 0", BitCount, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_bounce();
    test_timeout();
    test_present_press();
    test_clear();
    test_reset_present();
    tick(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_codes: got %0d codes never presented want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_entry_collector.md
Name: key_entry_collector

Overview:
Upstream stage of the input-key decoder FSM. Debounces a raw strobe pushbutton and samples a bit switch on each press. Assembles KEY_WIDTH bits MSB-first, then presents the completed code on InputKey with ValidCmd held high for HOLD_CYCLES clocks, matching the decoder's InputKey/ValidCmd interface. Partial entries are discarded on a Clear or after an idle timeout.

Parameters:
KEY_WIDTH, 5, bits per key code; must equal the decoder's InputKey width.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before the debounced strobe changes (>=1).
HOLD_CYCLES, 5, number of cycles ValidCmd stays high per completed code (>=1).
TIMEOUT_CYCLES, 64, idle cycles in COLLECT before the partial entry is discarded (>=2).

Ports:
Clk  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
KeyBit  input  1  raw bit-value switch, asynchronous, 2-FF synchronized internally
StrobeBtn  input  1  raw pushbutton, asynchronous, bouncy; a press commits one bit
ClearBtn  input  1  raw clear button, asynchronous, 2-FF synchronized, level-sensitive
InputKey  output  KEY_WIDTH  last completed key code; to decoder InputKey
ValidCmd  output  1  high for exactly HOLD_CYCLES cycles per completed code; to decoder ValidCmd
BitCount  output  $clog2(KEY_WIDTH+1)  bits collected in the current partial entry
Busy  output  1  high in COLLECT or PRESENT

Behaviour:
- Reset (sync, high): all outputs 0; shift register, counters and sync flops 0; debounced strobe 0; FSM to IDLE. Reset overrides everything, including mid-PRESENT: ValidCmd is 0 after the reset edge.
- Sync: KeyBit, StrobeBtn and ClearBtn each pass through 2 flops; all logic below uses the synchronized versions.
- Debounce: counter increments while sync strobe != debounced level and clears when equal. The debounced level toggles on the edge where the counter reaches DEBOUNCE_CYCLES. A press event is a registered 1-cycle pulse on the debounced rising edge. Releases generate no event.
- Latency: if raw StrobeBtn rises before edge E0 and stays high, the bit is shifted at edge E0+DEBOUNCE_CYCLES+3. The sampled value is synchronized KeyBit at that edge. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.
- Shift: shreg <= {shreg[KEY_WIDTH-2:0], bit}, so the first bit entered ends up at the MSB. BitCount increments on each accepted press.
- FSM:
  - IDLE: a press moves to COLLECT, stores the bit, and sets BitCount=1.
  - COLLECT: a press stores the bit. On the press that makes KEY_WIDTH bits: InputKey <= completed code, ValidCmd <= 1, BitCount <= 0, go to PRESENT.
  - COLLECT timeout: an idle counter clears on each press. At TIMEOUT_CYCLES idle cycles: shreg and BitCount cleared, go to IDLE. InputKey is not changed.
  - PRESENT: ValidCmd high for exactly HOLD_CYCLES cycles, then 0 and return to IDLE. Presses are ignored (dropped, not queued).
  - InputKey holds its value after ValidCmd falls, until the next completed code, Clear, or Reset.
- Clear (sync ClearBtn high, any state): next edge clears shreg, BitCount, ValidCmd and InputKey, and goes to IDLE. Clear wins over a simultaneous press or completion.
- Busy = (state != IDLE), registered with the state.

Test Plan:
- Reset: hold Reset 2 cycles with toggling inputs -> InputKey=0, ValidCmd=0, BitCount=0, Busy=0.
- Entry 1,0,1,0,1 with clean 10-cycle presses (DEBOUNCE_CYCLES=4) -> InputKey=5'b10101; ValidCmd high exactly 5 cycles starting at the 5th press edge (E0+7); InputKey stays 10101 afterwards.
- Bounce: strobe pulses of 1–3 cycles separated by 1-cycle gaps, then a clean press with KeyBit=1 -> exactly one bit accepted, BitCount=1.
- Timeout: enter 3 bits, then idle 64 cycles -> BitCount=0, Busy=0, no ValidCmd. A following full entry 00001 -> InputKey=5'b00001.
- Press during PRESENT: 6th press inside the hold window -> ignored; BitCount stays 0 after the return to IDLE.
- Clear and Reset mid-operation: ClearBtn after 4 bits, on the same cycle as the 5th press -> no ValidCmd, InputKey=0. Reset asserted during PRESENT -> ValidCmd=0 on the next edge.
